// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Two-master round-robin arbiter and sequencer for the CPU data-side
// peripheral bus. Masters m0 (CPU data port) and m1 (debug/loader engine)
// share one device port that reaches data memory (DM), timer 0 (T0) and
// timer 1 (T1). Each granted request is decoded and checked for legality,
// then either refused immediately or issued as a one-cycle device strobe.
// The device acknowledge is awaited with a bounded timeout, and the result
// is returned to the requester as a one-cycle ack with err and rdata.
// Illegal accesses never reach a device.

module periph_bus_arbiter #(
  // Maximum WAIT cycles without dev_ack before an error response (2..31).
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,

  // Master 0: CPU data port
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  // Master 1: debug / loader engine
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  // Shared device port
  output logic        dev_stb,
  output logic [2:0]  dev_sel,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_be,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata
);

  // ---------------------------------------------------------------------
  // Address map and device select encoding
  // ---------------------------------------------------------------------
  localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
  localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] T0_LAST  = 32'h0000_7F0B;
  localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] T1_LAST  = 32'h0000_7F1B;
  // Timer count registers are read-only.
  localparam logic [31:0] T0_COUNT = 32'h0000_7F08;
  localparam logic [31:0] T1_COUNT = 32'h0000_7F18;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_DM   = 3'b001;
  localparam logic [2:0] SEL_T0   = 3'b010;
  localparam logic [2:0] SEL_T1   = 3'b100;

  // Wide enough for the largest legal TIMEOUT (31).
  localparam int unsigned       CNT_W    = 5;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Request fields of one master, as carried onto the device port.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  // ---------------------------------------------------------------------
  // Decode and legality helpers
  // ---------------------------------------------------------------------

  // One-hot device select for an address; SEL_NONE when unmapped.
  function automatic logic [2:0] decode_dev(input logic [31:0] addr);
    if (addr <= DM_LAST)                      return SEL_DM;
    if (addr >= T0_BASE && addr <= T0_LAST)   return SEL_T0;
    if (addr >= T1_BASE && addr <= T1_LAST)   return SEL_T1;
    return SEL_NONE;
  endfunction

  // Byte enables must form a naturally aligned word, half or byte that
  // matches the low address bits. Anything else (including 0000) is refused.
  function automatic logic lanes_ok(input logic [3:0] be, input logic [1:0] offset);
    case (be)
      4'b1111: return offset == 2'd0;
      4'b0011: return offset == 2'd0;
      4'b1100: return offset == 2'd2;
      4'b0001: return offset == 2'd0;
      4'b0010: return offset == 2'd1;
      4'b0100: return offset == 2'd2;
      4'b1000: return offset == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_count_reg(input logic [31:0] addr);
    return (addr == T0_COUNT) || (addr == T1_COUNT);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state;
  logic             prio_m1;    // 1: m1 wins a tie, 0: m0 wins a tie
  logic             owner_m1;   // master that owns the transaction in flight
  logic [CNT_W-1:0] wait_cnt;   // WAIT cycles elapsed without dev_ack

  // Arbitration / check results for the current IDLE cycle
  logic             any_req;
  logic             grant_m1;
  bus_req_t         win_req;
  logic [2:0]       win_sel;
  logic             win_legal;

  // Response that completes a transaction this cycle, if any
  logic             rsp_valid;
  logic             rsp_to_m1;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;
  logic             wait_expired;

  // Pick the round-robin winner and vet its access before anything is issued.
  always_comb begin
    // NOTE: every signal written in a combinational block is given a default
    // first; a path that left one unassigned would infer a latch.
    any_req  = m0_req | m1_req;
    grant_m1 = m1_req & (~m0_req | prio_m1);

    if (grant_m1) begin
      win_req = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
    end else begin
      win_req = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
    end

    win_sel   = decode_dev(win_req.addr);
    win_legal = (win_sel != SEL_NONE)
              && lanes_ok(win_req.be, win_req.addr[1:0])
              && ((win_sel == SEL_DM) || (win_req.be == 4'b1111))
              && !(win_req.we && is_count_reg(win_req.addr));
  end

  // Form the completion for this cycle: an immediate refusal in IDLE, or the
  // device acknowledge / timeout in WAIT. dev_ack is ignored everywhere else.
  always_comb begin
    rsp_valid    = 1'b0;
    rsp_to_m1    = owner_m1;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    wait_expired = (wait_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (any_req && !win_legal) begin
          rsp_valid = 1'b1;
          rsp_to_m1 = grant_m1;
          rsp_err   = 1'b1;
        end
      end
      WAIT: begin
        if (dev_ack) begin
          rsp_valid = 1'b1;
          // Writes return zero rather than whatever the device drives.
          rsp_rdata = dev_we ? '0 : dev_rdata;
        end else if (wait_expired) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer: state, priority pointer, device port and master responses.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order in the block.
    if (reset) begin
      state     <= IDLE;
      prio_m1   <= 1'b0;
      owner_m1  <= 1'b0;
      wait_cnt  <= '0;
      dev_stb   <= 1'b0;
      dev_sel   <= SEL_NONE;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      // Strobe and acks are single-cycle pulses; err/rdata are only
      // non-zero alongside an ack.
      dev_stb  <= 1'b0;
      m0_ack   <= rsp_valid & ~rsp_to_m1;
      m0_err   <= rsp_valid & ~rsp_to_m1 & rsp_err;
      m0_rdata <= (rsp_valid & ~rsp_to_m1) ? rsp_rdata : '0;
      m1_ack   <= rsp_valid & rsp_to_m1;
      m1_err   <= rsp_valid & rsp_to_m1 & rsp_err;
      m1_rdata <= (rsp_valid & rsp_to_m1) ? rsp_rdata : '0;

      case (state)
        IDLE: begin
          if (any_req) begin
            // The loser of this grant is favoured next time.
            prio_m1  <= ~grant_m1;
            owner_m1 <= grant_m1;
            if (win_legal) begin
              dev_stb   <= 1'b1;
              dev_sel   <= win_sel;
              dev_we    <= win_req.we;
              dev_addr  <= win_req.addr;
              dev_wdata <= win_req.wdata;
              dev_be    <= win_req.be;
              state     <= ISSUE;
            end else begin
              // Refused: dev_sel stays clear and no strobe is issued.
              state <= RESP;
            end
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (rsp_valid) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          dev_sel <= SEL_NONE;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter
// Self-checking bench for periph_bus_arbiter: a table of single-master
// transactions with hand-derived results, hand-written sequences for
// arbitration, timeout and mid-transaction reset, and a randomized run
// against a transaction-level reference model of the arbiter.

module tb_periph_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;

  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;

  logic        dev_stb;
  logic [2:0]  dev_sel;
  logic        dev_we;
  logic [31:0] dev_addr, dev_wdata;
  logic [3:0]  dev_be;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_be     (m0_be),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_be     (m1_be),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .dev_stb   (dev_stb),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_be    (dev_be),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // Advance to just after the next rising edge; outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_master(input bit m, input logic req, input logic we,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dev_ack   = 1'b0;
    dev_rdata = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  // One transaction on master m, starting in an IDLE cycle (cycle 0).
  // The device acks dly WAIT cycles after the first one (dly<0: never), and
  // also pulses dev_ack with junk data in the ISSUE cycle, which must be
  // ignored. Returns the ack cycle (-1 if none), err, rdata, strobe count
  // and the dev_sel seen with the strobe. Ends in the following IDLE cycle.
  task automatic xact(input bit m, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] drd, input int dly,
                      output int ack_cyc, output logic err,
                      output logic [31:0] rd, output int stbs,
                      output logic [2:0] sel);
    int  cyc     = 0;
    int  stb_cyc = -1;
    bit  ack_now;
    ack_cyc = -1; err = 1'b0; rd = 32'h0; stbs = 0; sel = 3'b000;
    set_master(m, 1'b1, we, addr, be, wd);
    while (ack_cyc < 0 && cyc < 60) begin
      ack_now   = (stb_cyc >= 0) && (dly >= 0) && (cyc == stb_cyc + 1 + dly);
      dev_ack   = ack_now || ((stb_cyc >= 0) && (cyc == stb_cyc));
      dev_rdata = ack_now ? drd : $urandom();
      tick();
      cyc++;
      if (dev_stb) begin
        stbs++;
        stb_cyc = cyc;
        sel     = dev_sel;
        check("stb_fields", {dev_we, dev_addr, dev_wdata, dev_be}, {we, addr, wd, be});
      end
      check("other_ack", m ? m0_ack : m1_ack, 1'b0);
      if (m ? m1_ack : m0_ack) begin
        ack_cyc = cyc;
        err     = m ? m1_err : m0_err;
        rd      = m ? m1_rdata : m0_rdata;
      end
    end
    set_master(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dev_ack = 1'b0;
    tick();
    check("ack_pulse", m ? m1_ack : m0_ack, 1'b0);
  endtask

  // ---------------------------------------------------------------------
  // Reference model rules (address map and access legality)
  // ---------------------------------------------------------------------
  function automatic logic [2:0] ref_dev(input logic [31:0] a);
    if (a < 32'h3000)                          return 3'b001;
    if (a >= 32'h7F00 && (a - 32'h7F00) < 12)  return 3'b010;
    if (a >= 32'h7F10 && (a - 32'h7F10) < 12)  return 3'b100;
    return 3'b000;
  endfunction

  // Legal when the enabled lanes form one contiguous, naturally aligned
  // access of 1, 2 or 4 bytes starting at the byte the address names,
  // timers only take full words, and timer count registers are not written.
  function automatic bit ref_legal(input logic we, input logic [31:0] a, input logic [3:0] be);
    int n;
    int low;
    int off;
    logic [2:0] dev;
    dev = ref_dev(a);
    n   = $countones(be);
    low = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) low = i;
    off = int'(a[1:0]);
    if (dev == 3'b000)                          return 1'b0;
    if (!(n == 1 || n == 2 || n == 4))          return 1'b0;
    if (be != 4'(((1 << n) - 1) << low))        return 1'b0;
    if (off != low || (off % n) != 0)           return 1'b0;
    if (dev != 3'b001 && n != 4)                return 1'b0;
    if (we && (a == 32'h7F08 || a == 32'h7F18)) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] drd;
    int          dly;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_ack;
    logic [2:0]  exp_sel;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] drd, input int dly,
                              input logic ee, input logic [31:0] er, input int ea,
                              input logic [2:0] es);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.drd = drd; v.dly = dly;
    v.exp_err = ee; v.exp_rd = er; v.exp_ack = ea; v.exp_sel = es;
    return v;
  endfunction

  localparam int NV = 16;
  vec_t vecs [NV];

  // Scratch for transactions and sequences
  int          ack_cyc, stbs;
  logic        err;
  logic [31:0] rd;
  logic [2:0]  sel;
  int          stb_c[$];
  logic [31:0] stb_a[$];
  int          a0[$];
  int          a1[$];
  int          last_stb;
  bit          seen;

  // Random-phase model state
  bit          pend [2];
  logic        we_q [2];
  logic [31:0] addr_q [2];
  logic [31:0] wd_q [2];
  logic [3:0]  be_q [2];
  bit          busy, ptr1, own;
  int          g, free_at;
  bit          exp_ack [2];
  logic        exp_err;
  logic [31:0] exp_rd;
  bit          exp_stb;
  logic [2:0]  exp_sel;

  logic [31:0] addr_pool [16] = '{32'h0, 32'h4, 32'h2, 32'h3, 32'h1, 32'h2FFC, 32'h2FFF, 32'h3000,
                                  32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10, 32'h7F18,
                                  32'h7F1A, 32'h7F1C};
  logic [3:0]  be_pool [9] = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  initial begin
    //        we    addr          be    wdata         drd           dly err rdata        ack sel
    vecs[0]  = mk(0, 32'h0000_0010, 4'hF, 32'h0,        32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 3, 3'b001);
    vecs[1]  = mk(1, 32'h0000_7F08, 4'hF, 32'h1,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[2]  = mk(1, 32'h0000_7F1A, 4'h4, 32'h00AA0000, 32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[3]  = mk(0, 32'h0000_3028, 4'hF, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[4]  = mk(0, 32'h0000_0001, 4'hF, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[5]  = mk(1, 32'h0000_0003, 4'h8, 32'h11000000, 32'hFFFFFFFF, 0,  0, 32'h0,        3, 3'b001);
    vecs[6]  = mk(0, 32'h0000_0002, 4'hC, 32'h0,        32'hCAFE0000, 0,  0, 32'hCAFE0000, 3, 3'b001);
    vecs[7]  = mk(0, 32'h0000_0001, 4'h3, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[8]  = mk(0, 32'h0000_7F08, 4'hF, 32'h0,        32'h00000123, 1,  0, 32'h00000123, 4, 3'b010);
    vecs[9]  = mk(1, 32'h0000_7F00, 4'hF, 32'h5,        32'h0,        2,  0, 32'h0,        5, 3'b010);
    vecs[10] = mk(0, 32'h0000_2FFF, 4'h8, 32'h0,        32'h77000000, 0,  0, 32'h77000000, 3, 3'b001);
    vecs[11] = mk(0, 32'h0000_7F0C, 4'hF, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[12] = mk(0, 32'h0000_0000, 4'h0, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[13] = mk(1, 32'h0000_7F18, 4'hF, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);
    vecs[14] = mk(0, 32'h0000_7F14, 4'hF, 32'h0,        32'h00000009, 5,  0, 32'h00000009, 8, 3'b100);
    vecs[15] = mk(0, 32'h0000_3000, 4'hF, 32'h0,        32'h0,        0,  1, 32'h0,        1, 3'b000);

    // ---- Reset state ----
    do_reset();
    check("reset_dev", {dev_stb, dev_sel, dev_we, dev_addr, dev_wdata, dev_be}, '0);
    check("reset_masters", {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata}, '0);

    // ---- Table-driven single transactions on m0 ----
    for (int i = 0; i < NV; i++) begin
      xact(1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].drd,
           vecs[i].dly, ack_cyc, err, rd, stbs, sel);
      check($sformatf("v%0d_ack_cycle", i), ack_cyc, vecs[i].exp_ack);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_stb_count", i), stbs, (vecs[i].exp_sel != 3'b000) ? 1 : 0);
      check($sformatf("v%0d_sel", i), sel, vecs[i].exp_sel);
    end

    // ---- Timeout: m1 writes T1, device never answers ----
    do_reset();
    xact(1'b1, 1'b1, 32'h0000_7F14, 4'hF, 32'h5, 32'h0, -1, ack_cyc, err, rd, stbs, sel);
    check("timeout_ack_cycle", ack_cyc, 2 + TIMEOUT);
    check("timeout_err", err, 1'b1);
    check("timeout_rdata", rd, 32'h0);
    check("timeout_sel", sel, 3'b100);

    // ---- Round-robin: both request at cycle 0; m0 re-requests after ack ----
    do_reset();
    set_master(1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
    last_stb = -10;
    for (int cyc = 0; cyc < 16; cyc++) begin
      dev_ack   = (cyc == last_stb + 1);
      dev_rdata = {16'hA5A5, dev_addr[15:0]};
      tick();
      if (dev_stb) begin
        stb_c.push_back(cyc + 1);
        stb_a.push_back(dev_addr);
        last_stb = cyc + 1;
      end
      if (m0_ack) begin
        a0.push_back(cyc + 1);
        if (a0.size() >= 2) m0_req = 1'b0;
      end
      if (m1_ack) begin
        a1.push_back(cyc + 1);
        check("arb_m1_rdata", m1_rdata, 32'hA5A5_0104);
        m1_req = 1'b0;
      end
    end
    dev_ack = 1'b0;
    check("arb_stb_count", stb_c.size(), 3);
    check("arb_m0_acks", a0.size(), 2);
    check("arb_m1_acks", a1.size(), 1);
    if (stb_c.size() == 3) begin
      check("arb_stb0", {stb_c[0], stb_a[0]}, {32'd1, 32'h100});
      check("arb_stb1", {stb_c[1], stb_a[1]}, {32'd5, 32'h104});
      check("arb_stb2", {stb_c[2], stb_a[2]}, {32'd9, 32'h100});
    end
    if (a0.size() == 2) check("arb_m0_ack_cycles", {a0[0], a0[1]}, {32'd3, 32'd11});
    if (a1.size() == 1) check("arb_m1_ack_cycle", a1[0], 7);

    // ---- Reset during WAIT aborts the transaction ----
    do_reset();
    set_master(1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    dev_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    reset = 1'b0;
    check("abort_dev", {dev_stb, dev_sel, dev_we, dev_addr, dev_wdata, dev_be}, '0);
    check("abort_masters", {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata}, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dev_ack = (i == 2);
      tick();
      if (m0_ack || m1_ack || dev_stb) seen = 1'b1;
    end
    dev_ack = 1'b0;
    check("abort_quiet", seen, 1'b0);
    xact(1'b0, 1'b0, 32'h24, 4'hF, 32'h0, 32'h13579BDF, 0, ack_cyc, err, rd, stbs, sel);
    check("after_abort_ack_cycle", ack_cyc, 3);
    check("after_abort_result", {err, rd}, {1'b0, 32'h13579BDF});

    // ---- Randomized run against the reference model ----
    do_reset();
    pend = '{0, 0};
    busy = 1'b0; ptr1 = 1'b0; own = 1'b0; g = 0; free_at = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 3) == 0) begin
          pend[m]   = 1'b1;
          we_q[m]   = 1'($urandom_range(0, 1));
          addr_q[m] = ($urandom_range(0, 7) == 0) ? $urandom() : addr_pool[$urandom_range(0, 15)];
          be_q[m]   = be_pool[$urandom_range(0, 8)];
          wd_q[m]   = $urandom();
        end
        set_master(m[0], pend[m], we_q[m], addr_q[m], be_q[m], wd_q[m]);
      end
      dev_ack   = ($urandom_range(0, 3) == 0);
      dev_rdata = $urandom();

      exp_ack = '{0, 0}; exp_err = 1'b0; exp_rd = 32'h0; exp_stb = 1'b0; exp_sel = 3'b000;
      if (!busy) begin
        if (c >= free_at && (pend[0] || pend[1])) begin
          own  = pend[1] && (!pend[0] || ptr1);
          ptr1 = !own;
          g    = c;
          if (ref_legal(we_q[own], addr_q[own], be_q[own])) begin
            busy    = 1'b1;
            exp_stb = 1'b1;
            exp_sel = ref_dev(addr_q[own]);
          end else begin
            exp_ack[own] = 1'b1;
            exp_err      = 1'b1;
            free_at      = c + 2;
          end
        end
      end else if (c >= g + 2) begin
        if (dev_ack) begin
          exp_ack[own] = 1'b1;
          exp_rd       = we_q[own] ? 32'h0 : dev_rdata;
          busy         = 1'b0;
          free_at      = c + 2;
        end else if (c == g + 1 + TIMEOUT) begin
          exp_ack[own] = 1'b1;
          exp_err      = 1'b1;
          busy         = 1'b0;
          free_at      = c + 2;
        end
      end

      tick();
      check("rnd_m0", {m0_ack, m0_err, m0_rdata},
            {exp_ack[0], exp_ack[0] & exp_err, exp_ack[0] ? exp_rd : 32'h0});
      check("rnd_m1", {m1_ack, m1_err, m1_rdata},
            {exp_ack[1], exp_ack[1] & exp_err, exp_ack[1] ? exp_rd : 32'h0});
      check("rnd_stb", {dev_stb, dev_stb ? dev_sel : 3'b000}, {exp_stb, exp_sel});
      // A master usually drops req after its ack; sometimes it keeps it
      // high, which is a fresh request with the same fields.
      for (int m = 0; m < 2; m++) begin
        if (exp_ack[m] && $urandom_range(0, 3) != 0) pend[m] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on simulated time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and sequencer for the CPU data-side peripheral bus. It shares one device port among data memory (DM), timer 0 (T0) and timer 1 (T1) between the CPU data port (m0) and the debug/loader engine (m1). For each granted request it:
- performs address decode and access-legality checks;
- issues a single-cycle device strobe and waits for the device acknowledge, with a timeout;
- returns a one-cycle acknowledge with read data and an error flag to the requester.

Illegal accesses never reach a device.

## Interface
- TIMEOUT, 16 — maximum WAIT cycles without `dev_ack` before an error response; legal range 2..31.
- clk  in  1  — single system clock; all logic is on its rising edge.
- reset  in  1  — synchronous, active-high.
- m0_req / m1_req  in  1  — request; held stable with all m*_ fields until the matching ack.
- m0_we / m1_we  in  1  — 1 = write.
- m0_addr / m1_addr  in  32  — byte address.
- m0_wdata / m1_wdata  in  32  — write data, lane-aligned.
- m0_be / m1_be  in  4  — byte enables.
- m0_ack / m1_ack  out  1  — one-cycle completion pulse.
- m0_err / m1_err  out  1  — valid with ack; 1 = access refused or timed out.
- m0_rdata / m1_rdata  out  32  — valid with ack on a successful read; 0 otherwise.
- dev_stb  out  1  — one-cycle device access strobe.
- dev_sel  out  3  — one-hot device select: bit0 DM, bit1 T0, bit2 T1. Held from ISSUE through RESP.
- dev_we, dev_addr[31:0], dev_wdata[31:0], dev_be[3:0]  out  — latched request fields. Held from ISSUE through RESP.
- dev_ack  in  1  — device done; sampled only in WAIT.
- dev_rdata  in  32  — captured in the `dev_ack` cycle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The next state is registered.
- IDLE, no req: stay in IDLE.
- IDLE, one or both req: select the winner by round-robin.
  - Priority goes to the master not granted last.
  - The priority pointer resets to favour m0.
  - The pointer updates only on grant.
- In IDLE, the winner's fields are latched and checked combinationally. The checks are:
  - Range: addr in 0x0000_0000–0x0000_2FFF selects DM; 0x7F00–0x7F0B selects T0; 0x7F10–0x7F1B selects T1. Any other address is an error.
  - Enable/alignment:
    - 1111 requires addr[1:0]=00.
    - 0011 requires addr[1:0]=00.
    - 1100 requires addr[1:0]=10.
    - A one-hot byte enable requires addr[1:0] equal to the set bit index.
    - Any other be value, including 0000, is an error.
  - Timer width: T0/T1 accept be=1111 only. Sub-word timer accesses are errors.
  - Count register read-only: a write to 0x7F08 or 0x7F18 is an error. Reads are legal.
- Check failed: go to RESP with err=1. No dev_stb is issued and dev_sel stays 000.
- Check passed: go to ISSUE.
- ISSUE: dev_stb=1 for exactly one cycle, then go to WAIT. The timeout counter is cleared to 0.
- WAIT:
  - dev_ack=1: capture dev_rdata (reads only; writes capture 0), set err=0, go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no ack: go to RESP with err=1 and rdata=0.
- RESP: the granted master's ack=1 for one cycle with err/rdata valid. The other master's ack stays 0. Then return to IDLE.
- Edge cases:
  - dev_ack outside WAIT is ignored.
  - A request arriving while busy waits; it is never dropped.
  - A master that keeps req high in the IDLE cycle after its ack is treated as issuing a new request.

## Timing
- Reset (synchronous, takes effect at the edge where reset=1):
  - state=IDLE, pointer favours m0.
  - dev_stb=0, dev_sel=000, dev_we=0, dev_be=0000, dev_addr/dev_wdata=0.
  - m*_ack=0, m*_err=0, m*_rdata=0.
- Reset mid-transaction aborts it: no ack is issued for the aborted request, and dev_stb is low from the next cycle.
- All outputs are registered.
- Error latency: req seen in IDLE at cycle 0, ack at cycle 1.
- Success latency:
  - req in IDLE at cycle 0, dev_stb at cycle 1, WAIT from cycle 2.
  - dev_ack at cycle k (k≥2) gives ack at cycle k+1.
  - Minimum request-to-ack latency is 3 cycles.
- Timeout: with no dev_ack, err-ack arrives at cycle 2+TIMEOUT (cycle 18 at the default).
- Back-to-back: after RESP, the next grant occurs in the following IDLE cycle. One idle cycle separates transactions.

## Test plan
- m0 read 0x0000_0010, be=1111; dev_ack at cycle 2 with dev_rdata=0xDEADBEEF. Required: dev_sel=001 and dev_stb at cycle 1; m0_ack at cycle 3 with rdata=0xDEADBEEF, err=0.
- Refused accesses, one each: m0 writes 0x7F08 be=1111; m0 writes 0x7F1A be=0100; m0 reads 0x0000_3028; m0 reads 0x0000_0001 be=1111. Required: each gives m0_ack at cycle 1 with err=1, and dev_stb never asserts.
- m0 and m1 both request at cycle 0 after reset. Required: m0 served first; m1 gets dev_stb in the IDLE+1 cycle after m0's RESP. In a second simultaneous round, m1 wins.
- m1 writes T1 0x7F14 be=1111, wdata=0x5; dev_ack never arrives. Required: m1_ack at cycle 18 with err=1 and rdata=0.
- Byte-lane legality: m0 byte write 0x0000_0003 be=1000 is accepted; m0 half read 0x0000_0002 be=1100 is accepted; m0 half read 0x0000_0001 be=0011 gives err=1.
- Assert reset during WAIT. Required: no m*_ack; all outputs 0 the next cycle; a later m0 request is served normally.
